pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the Otter 5-stage pipeline: IF, DE, EX, MEM, WB. It keeps an internal scoreboard of the instructions in EX, MEM and WB. It drives the stall, flush and bubble controls for the PC, IF/DE and DE/EX registers. It also drives the forwarding selects for the decode-stage ALU operand muxes, and maintains saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - Otter 5-stage pipeline hazard, forwarding and stall/flush controller
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             DE_VALID,
    input  logic [4:0]       DE_RS1,
    input  logic [4:0]       DE_RS2,
    input  logic             DE_USES_RS1,
    input  logic             DE_USES_RS2,
    input  logic [4:0]       DE_RD,
    input  logic             DE_REG_WRITE,
    input  logic             DE_MEM_READ,
    input  logic             EX_BRANCH_TAKEN,
    input  logic             MEM_BUSY,
    output logic             PC_STALL,
    output logic             IF_DE_STALL,
    output logic             IF_DE_FLUSH,
    output logic             DE_EX_BUBBLE,
    output logic             EX_MEM_HOLD,
    output logic [1:0]       FWD_A_SEL,
    output logic [1:0]       FWD_B_SEL,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_COUNT,
    output logic [CNT_W-1:0] FLUSH_COUNT
);

    typedef enum logic [1:0] {
        S_RUN        = 2'b00,
        S_LOAD_STALL = 2'b01,
        S_FREEZE     = 2'b10
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } sb_entry_t;

    state_t            state_q, state_d;
    sb_entry_t         ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic freeze, flush, load_use, pc_stall, quiet;
    sb_entry_t de_entry;

    // x0 is hard-wired zero, so a writer of x0 never produces a dependency
    function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] src);
        return e.valid && e.reg_write && (e.rd != 5'd0) && (e.rd == src);
    endfunction

    // Youngest producer wins; a load in EX has no data yet and is covered by load_use
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] src,
                                           input sb_entry_t ex, input sb_entry_t mem,
                                           input sb_entry_t wb);
        if (!uses)                                 return 2'b00;
        else if (sb_hit(ex, src) && !ex.mem_read)  return 2'b01;
        else if (sb_hit(mem, src))                 return 2'b10;
        else if (sb_hit(wb, src))                  return 2'b11;
        else                                       return 2'b00;
    endfunction

    always_comb begin
        freeze   = MEM_BUSY;
        flush    = EX_BRANCH_TAKEN & ~freeze;
        load_use = DE_VALID & ex_q.mem_read & ~freeze & ~flush &
                   ((DE_USES_RS1 & sb_hit(ex_q, DE_RS1)) |
                    (DE_USES_RS2 & sb_hit(ex_q, DE_RS2)));
        pc_stall = freeze | load_use;
        quiet    = freeze | flush | load_use;

        de_entry = '{valid: DE_VALID, rd: DE_RD, reg_write: DE_REG_WRITE, mem_read: DE_MEM_READ};

        PC_STALL     = RST_N & pc_stall;
        IF_DE_STALL  = RST_N & pc_stall;
        IF_DE_FLUSH  = RST_N & flush;
        DE_EX_BUBBLE = RST_N & (flush | load_use);
        EX_MEM_HOLD  = RST_N & freeze;
        FWD_A_SEL    = (RST_N && !quiet) ? fwd_sel(DE_USES_RS1, DE_RS1, ex_q, mem_q, wb_q) : 2'b00;
        FWD_B_SEL    = (RST_N && !quiet) ? fwd_sel(DE_USES_RS2, DE_RS2, ex_q, mem_q, wb_q) : 2'b00;
        STATE        = state_q;
        STALL_COUNT  = stall_cnt_q;
        FLUSH_COUNT  = flush_cnt_q;
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = (flush || load_use) ? '0 : de_entry;
        end

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (freeze)        state_d = S_FREEZE;
                else if (load_use) state_d = S_LOAD_STALL;
            end
            S_LOAD_STALL: state_d = freeze ? S_FREEZE : S_RUN;
            S_FREEZE:     state_d = MEM_BUSY ? S_FREEZE : S_RUN;
            default:      state_d = S_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
